// File: rtl/sha256_msg_packer.sv
// Single-block SHA-256 message padder between the UART receiver and the core.
// Buffers up to 55 bytes, pads them into 512 bits and streams 16 words.
module sha256_msg_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BYTES  = 55
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_dv_in,
    input  logic [7:0]            rx_byte_in,
    input  logic                  rx_last_in,
    input  logic                  core_idle_in,
    output logic                  mp_dv_out,
    output logic [DATA_WIDTH-1:0] message_out,
    output logic                  busy_out,
    output logic                  len_err_out,
    output logic                  drop_err_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_PAD,
        S_EMIT,
        S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  msg_buf [64];
    logic [6:0]  byte_cnt;
    logic [3:0]  word_idx;
    logic        ovf_q, ovf_d;
    logic        wait_arm;
    logic        len_err_q, len_err_d;
    logic        drop_err_q, drop_d;
    logic        byte_wr;
    logic        room;
    logic [63:0] bit_len;
    logic [31:0] word;

    assign room    = byte_cnt < 7'(MAX_BYTES);
    assign bit_len = {54'b0, byte_cnt, 3'b000};

    always_comb begin
        state_d   = state_q;
        byte_wr   = 1'b0;
        ovf_d     = ovf_q;
        len_err_d = 1'b0;
        drop_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rx_dv_in) begin
                    byte_wr = 1'b1;
                    state_d = rx_last_in ? S_PAD : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (rx_dv_in) begin
                    byte_wr = room;
                    ovf_d   = ovf_q | ~room;
                    if (rx_last_in) begin
                        len_err_d = ovf_d;
                        state_d   = ovf_d ? S_IDLE : S_PAD;
                    end
                end
            end
            S_PAD: begin
                drop_d  = rx_dv_in;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                drop_d = rx_dv_in;
                if (word_idx == 4'd15)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                drop_d = rx_dv_in;
                // first WAIT cycle ignores idle so the core can leave it
                if (wait_arm && core_idle_in)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= '0;
            word_idx   <= '0;
            ovf_q      <= 1'b0;
            wait_arm   <= 1'b0;
            len_err_q  <= 1'b0;
            drop_err_q <= 1'b0;
            for (int i = 0; i < 64; i++)
                msg_buf[i] <= 8'h00;
        end else begin
            len_err_q  <= len_err_d;
            drop_err_q <= drop_d;
            ovf_q      <= ovf_d;
            if (byte_wr) begin
                msg_buf[byte_cnt[5:0]] <= rx_byte_in;
                byte_cnt               <= byte_cnt + 7'd1;
            end
            if (len_err_d) begin
                byte_cnt <= '0;
                ovf_q    <= 1'b0;
                for (int i = 0; i < 64; i++)
                    msg_buf[i] <= 8'h00;
            end
            if (state_q == S_PAD) begin
                for (int i = 0; i < 56; i++)
                    if (i > int'(byte_cnt))
                        msg_buf[i] <= 8'h00;
                msg_buf[byte_cnt[5:0]] <= 8'h80;
                for (int j = 0; j < 8; j++)
                    msg_buf[56+j] <= bit_len[63-8*j -: 8];
                word_idx <= '0;
            end
            if (state_q == S_EMIT) begin
                word_idx <= word_idx + 4'd1;
                wait_arm <= 1'b0;
            end
            if (state_q == S_WAIT) begin
                wait_arm <= 1'b1;
                if (state_d == S_IDLE)
                    byte_cnt <= '0;
            end
        end
    end

    assign word = {msg_buf[{word_idx, 2'b00}],
                   msg_buf[{word_idx, 2'b01}],
                   msg_buf[{word_idx, 2'b10}],
                   msg_buf[{word_idx, 2'b11}]};

    assign mp_dv_out    = (state_q == S_EMIT);
    assign message_out  = mp_dv_out ? DATA_WIDTH'(word) : '0;
    assign busy_out     = (state_q != S_IDLE) && (state_q != S_COLLECT);
    assign len_err_out  = len_err_q;
    assign drop_err_out = drop_err_q;

endmodule
